// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one multiplier-accumulator reused over NTAPS cycles per sample.
// Full-precision output; define FIR_DROP_CNT_EN to add the o_drop_cnt overrun counter.

module fir_serial_mac #(
   parameter int unsigned NTAPS  = 8,
   parameter int unsigned NB_X   = 8,
   parameter int unsigned NB_C   = 8,
   parameter int unsigned NB_ACC = NB_X + NB_C + $clog2(NTAPS)
) (
   input  logic                     clk,
   input  logic                     i_reset,
   input  logic                     i_valid,
   input  logic [NB_X-1:0]          i_data,
   output logic                     o_ready,
   input  logic                     i_coef_we,
   input  logic [$clog2(NTAPS)-1:0] i_coef_addr,
   input  logic [NB_C-1:0]          i_coef_data,
   output logic                     o_valid,
   output logic [NB_ACC-1:0]        o_data
`ifdef FIR_DROP_CNT_EN
   ,
   output logic [15:0]              o_drop_cnt
`endif
);

   localparam int unsigned NB_CNT  = $clog2(NTAPS);
   localparam int unsigned NB_PROD = NB_X + NB_C;
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NTAPS - 1);

   typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

   state_e                    state_q, state_d;
   logic [NB_CNT-1:0]         cnt_q, cnt_d;
   logic signed [NB_ACC-1:0]  acc_q, acc_d;
   logic signed [NB_X-1:0]    x_q [NTAPS];
   logic signed [NB_X-1:0]    x_d [NTAPS];
   logic signed [NB_C-1:0]    c_q [NTAPS];
   logic signed [NB_C-1:0]    c_d [NTAPS];
   logic                      o_valid_q, o_valid_d;
   logic [NB_ACC-1:0]         o_data_q, o_data_d;

   logic signed [NB_PROD-1:0] prod;
   logic signed [NB_ACC-1:0]  prod_ext;

   // Size casts of signed operands sign-extend, so the product is exact in NB_PROD bits.
   always_comb begin
      prod     = NB_PROD'(x_q[cnt_q]) * NB_PROD'(c_q[cnt_q]);
      prod_ext = NB_ACC'(prod);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      x_d       = x_q;
      c_d       = c_q;
      o_valid_d = 1'b0;
      o_data_d  = o_data_q;
      o_ready   = 1'b0;
      unique case (state_q)
         StIdle: begin
            o_ready = 1'b1;
            // Coefficients only change here, so a computation always sees a stable set.
            if (i_coef_we) begin
               c_d[i_coef_addr] = i_coef_data;
            end
            if (i_valid) begin
               x_d[0] = i_data;
               for (int unsigned k = 1; k < NTAPS; k++) begin
                  x_d[k] = x_q[k-1];
               end
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            acc_d = acc_q + prod_ext;
            cnt_d = cnt_q + NB_CNT'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = StDone;
            end
         end
         StDone: begin
            o_data_d  = acc_q;
            o_valid_d = 1'b1;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         for (int unsigned k = 0; k < NTAPS; k++) begin
            x_q[k] <= '0;
            c_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         x_q       <= x_d;
         c_q       <= c_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;

`ifdef FIR_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of samples offered while busy.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (i_valid && !o_ready && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_drop_cnt = drop_cnt_q;
`endif

endmodule
